// File: rtl/rsm_cpu_param.sv
// Multi-cycle Simple RISC Machine core with generic data width and register count.
// IR, decoder, two-process FSM controller, register file, shifter, ALU, and NVZ status flags.
module rsm_cpu_param #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREGS  = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              s_i,
  input  logic              load_i,
  input  logic [15:0]       in_i,
  output logic [DATA_W-1:0] out_o,
  output logic              n_o,
  output logic              v_o,
  output logic              z_o,
  output logic              w_o,
  output logic              halt_o
);

  localparam int unsigned IdxW = (NREGS > 1) ? $clog2(NREGS) : 1;

  // {op3, op2} encodings
  localparam logic [4:0] OpMovImm = 5'b11010;
  localparam logic [4:0] OpMov    = 5'b11000;
  localparam logic [4:0] OpAdd    = 5'b10100;
  localparam logic [4:0] OpCmp    = 5'b10101;
  localparam logic [4:0] OpAnd    = 5'b10110;
  localparam logic [4:0] OpMvn    = 5'b10111;
  localparam logic [4:0] OpHalt   = 5'b11100;

  typedef enum logic [2:0] {
    StWait, StDecode, StWimm, StGetA, StGetB, StExec, StWb, StHalt
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       ir_q;
  logic [DATA_W-1:0] a_q, b_q, out_q;
  logic              n_q, v_q, z_q, w_q, halt_q;
  logic [DATA_W-1:0] rf_q [NREGS];

  logic [4:0]        op;
  logic [1:0]        sh;
  logic [IdxW-1:0]   rn_idx, rd_idx, rm_idx;
  logic [DATA_W-1:0] imm_sx, sh_b, sum, diff, alu_res;
  logic              sub_ovf;

  assign op     = ir_q[15:11];
  assign sh     = ir_q[4:3];
  assign rn_idx = ir_q[8 +: IdxW];
  assign rd_idx = ir_q[5 +: IdxW];
  assign rm_idx = ir_q[0 +: IdxW];
  assign imm_sx = DATA_W'($signed(ir_q[7:0]));

  // Shifter on the B operand, then ALU
  always_comb begin
    sh_b = b_q;
    case (sh)
      2'b01:   sh_b = {b_q[DATA_W-2:0], 1'b0};
      2'b10:   sh_b = {1'b0, b_q[DATA_W-1:1]};
      2'b11:   sh_b = {b_q[DATA_W-1], b_q[DATA_W-1:1]};
      default: sh_b = b_q;
    endcase
    sum     = a_q + sh_b;
    diff    = a_q - sh_b;
    sub_ovf = (a_q[DATA_W-1] ^ sh_b[DATA_W-1]) & (diff[DATA_W-1] ^ a_q[DATA_W-1]);
    case (op)
      OpAdd:   alu_res = sum;
      OpCmp:   alu_res = diff;
      OpAnd:   alu_res = a_q & sh_b;
      OpMvn:   alu_res = ~sh_b;
      default: alu_res = sh_b;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWait:   if (s_i) state_d = StDecode;
      StDecode: begin
        case (op)
          OpMovImm:                   state_d = StWimm;
          OpMov, OpMvn:               state_d = StGetB;
          OpAdd, OpCmp, OpAnd:        state_d = StGetA;
          OpHalt:                     state_d = StHalt;
          default:                    state_d = StWait;
        endcase
      end
      StGetA:   state_d = StGetB;
      StGetB:   state_d = StExec;
      StExec:   state_d = (op == OpCmp) ? StWait : StWb;
      StWb:     state_d = StWait;
      StWimm:   state_d = StWait;
      StHalt:   state_d = StHalt;
      default:  state_d = StWait;
    endcase
  end

  // State register plus registered status decodes
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StWait;
      w_q     <= 1'b1;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= (state_d == StWait);
      halt_q  <= (state_d == StHalt);
    end
  end

  // IR, operand latches, result register and flags
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ir_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      out_q <= '0;
      n_q   <= 1'b0;
      v_q   <= 1'b0;
      z_q   <= 1'b0;
    end else begin
      if (state_q == StWait && load_i) ir_q <= in_i;
      if (state_q == StGetA) a_q <= rf_q[rn_idx];
      if (state_q == StGetB) b_q <= rf_q[rm_idx];
      if (state_q == StExec) begin
        out_q <= alu_res;
        if (op == OpCmp) begin
          n_q <= diff[DATA_W-1];
          v_q <= sub_ovf;
          z_q <= (diff == '0);
        end
      end
    end
  end

  // Register file: result write-back at WB, sign-extended immediate at WIMM
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(NREGS); i++) rf_q[i] <= '0;
    end else if (state_q == StWb) begin
      rf_q[rd_idx] <= out_q;
    end else if (state_q == StWimm) begin
      rf_q[rn_idx] <= imm_sx;
    end
  end

  assign out_o  = out_q;
  assign n_o    = n_q;
  assign v_o    = v_q;
  assign z_o    = z_q;
  assign w_o    = w_q;
  assign halt_o = halt_q;

endmodule

// File: tb/tb_rsm_cpu_param.sv
// Bench for rsm_cpu_param: three instances (16-bit/8 regs, 8-bit/8 regs, 16-bit/4 regs).
module tb_rsm_cpu_param;

  logic        clk;
  logic        reset;
  logic        s_v    [3];
  logic        load_v [3];
  logic [15:0] in_v   [3];
  logic [15:0] out0, out2;
  logic [7:0]  out1;
  logic        n_v [3], v_v [3], z_v [3], w_v [3], halt_v [3];

  int checks = 0;
  int errors = 0;

  rsm_cpu_param #(.DATA_W(16), .NREGS(8)) u_dut0 (
    .clk_i(clk), .reset_i(reset), .s_i(s_v[0]), .load_i(load_v[0]), .in_i(in_v[0]),
    .out_o(out0), .n_o(n_v[0]), .v_o(v_v[0]), .z_o(z_v[0]), .w_o(w_v[0]), .halt_o(halt_v[0])
  );
  rsm_cpu_param #(.DATA_W(8), .NREGS(8)) u_dut1 (
    .clk_i(clk), .reset_i(reset), .s_i(s_v[1]), .load_i(load_v[1]), .in_i(in_v[1]),
    .out_o(out1), .n_o(n_v[1]), .v_o(v_v[1]), .z_o(z_v[1]), .w_o(w_v[1]), .halt_o(halt_v[1])
  );
  rsm_cpu_param #(.DATA_W(16), .NREGS(4)) u_dut2 (
    .clk_i(clk), .reset_i(reset), .s_i(s_v[2]), .load_i(load_v[2]), .in_i(in_v[2]),
    .out_o(out2), .n_o(n_v[2]), .v_o(v_v[2]), .z_o(z_v[2]), .w_o(w_v[2]), .halt_o(halt_v[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] get_out(input int d);
    if (d == 0) return out0;
    if (d == 1) return {8'h00, out1};
    return out2;
  endfunction

  function automatic logic [2:0] get_nvz(input int d);
    return {n_v[d], v_v[d], z_v[d]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Start an instruction on instance d and count the cycles w stays low (bounded).
  task automatic run_instr(input int d, input logic [15:0] ins, input logic ld, output int cyc);
    @(negedge clk);
    in_v[d] = ins; load_v[d] = ld; s_v[d] = 1'b1;
    @(posedge clk); #1;
    load_v[d] = 1'b0; s_v[d] = 1'b0;
    cyc = 0;
    while (w_v[d] == 1'b0 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  typedef struct {
    int          dut;
    logic [15:0] ins;
    int          cyc;
    logic [15:0] out;
    logic [2:0]  nvz;
  } vec_t;

  vec_t vecs [17];

  initial begin
    int cyc;

    vecs[0]  = '{0, 16'hD007, 2, 16'h0000, 3'b000}; // MOV R0,#7
    vecs[1]  = '{0, 16'hD102, 2, 16'h0000, 3'b000}; // MOV R1,#2
    vecs[2]  = '{0, 16'hA148, 5, 16'h0010, 3'b000}; // ADD R2,R1,R0 LSL1
    vecs[3]  = '{0, 16'hC002, 4, 16'h0010, 3'b000}; // MOV R0,R2
    vecs[4]  = '{0, 16'hB861, 4, 16'hFFFD, 3'b000}; // MVN R3,R1
    vecs[5]  = '{0, 16'hC09B, 4, 16'hFFFE, 3'b000}; // MOV R4,R3,ASR1
    vecs[6]  = '{0, 16'hC093, 4, 16'h7FFE, 3'b000}; // MOV R4,R3,LSR1
    vecs[7]  = '{0, 16'hB3A1, 5, 16'h0000, 3'b000}; // AND R5,R3,R1
    vecs[8]  = '{0, 16'h0000, 1, 16'h0000, 3'b000}; // NOP
    vecs[9]  = '{1, 16'hD080, 2, 16'h0000, 3'b000}; // MOV R0,#-128
    vecs[10] = '{1, 16'hD101, 2, 16'h0000, 3'b000}; // MOV R1,#1
    vecs[11] = '{1, 16'hA801, 4, 16'h007F, 3'b010}; // CMP R0,R1: overflow
    vecs[12] = '{1, 16'hA800, 4, 16'h0000, 3'b001}; // CMP R0,R0: zero
    vecs[13] = '{2, 16'hD503, 2, 16'h0000, 3'b000}; // MOV R5,#3 -> R1
    vecs[14] = '{2, 16'hC041, 4, 16'h0003, 3'b000}; // MOV R2,R1
    vecs[15] = '{2, 16'h0000, 1, 16'h0003, 3'b000}; // NOP
    vecs[16] = '{0, 16'hE800, 1, 16'h0000, 3'b000}; // 111/01: NOP, not HALT

    for (int i = 0; i < 3; i++) begin
      s_v[i] = 1'b0; load_v[i] = 1'b0; in_v[i] = 16'h0000;
    end
    reset = 1'b1;
    #2;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_w%0d", i), {31'd0, w_v[i]}, 32'd1);
      check($sformatf("rst_halt%0d", i), {31'd0, halt_v[i]}, 32'd0);
      check($sformatf("rst_out%0d", i), {16'd0, get_out(i)}, 32'd0);
      check($sformatf("rst_nvz%0d", i), {29'd0, get_nvz(i)}, 32'd0);
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("idle_w", {31'd0, w_v[0]}, 32'd1);
    end

    // Table-driven instruction vectors
    for (int i = 0; i < 17; i++) begin
      run_instr(vecs[i].dut, vecs[i].ins, 1'b1, cyc);
      check($sformatf("v%0d_cyc", i), cyc, vecs[i].cyc);
      check($sformatf("v%0d_out", i), {16'd0, get_out(vecs[i].dut)}, {16'd0, vecs[i].out});
      check($sformatf("v%0d_nvz", i), {29'd0, get_nvz(vecs[i].dut)}, {29'd0, vecs[i].nvz});
    end

    // load pulses during ADD are ignored (R0=16, R1=2 -> R2 = 2 + 32)
    @(negedge clk);
    in_v[0] = 16'hA148; load_v[0] = 1'b1; s_v[0] = 1'b1;
    @(posedge clk); #1;
    s_v[0] = 1'b0;
    in_v[0] = 16'hD0FF;
    cyc = 0;
    while (w_v[0] == 1'b0 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    load_v[0] = 1'b0;
    check("ldmid_cyc", cyc, 5);
    check("ldmid_out", {16'd0, out0}, 32'h0022);
    // Re-run with s only: IR must still hold the ADD
    run_instr(0, 16'h0000, 1'b0, cyc);
    check("ir_keep_cyc", cyc, 5);
    check("ir_keep_out", {16'd0, out0}, 32'h0022);
    // load+s together executes the new word
    run_instr(0, 16'hD0FF, 1'b1, cyc);
    check("ldst_cyc", cyc, 2);
    run_instr(0, 16'hC020, 1'b1, cyc); // MOV R1,R0
    check("ldst_r0", {16'd0, out0}, 32'hFFFF);

    // HALT: sticky, s and load ignored
    run_instr(0, 16'hE000, 1'b1, cyc);
    check("halt_cyc", cyc, 40);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("halt_h", {31'd0, halt_v[0]}, 32'd1);
      check("halt_w", {31'd0, w_v[0]}, 32'd0);
      s_v[0] = k[0]; load_v[0] = k[0]; in_v[0] = 16'hD001;
    end
    s_v[0] = 1'b0; load_v[0] = 1'b0;
    check("halt_out", {16'd0, out0}, 32'hFFFF);

    // Async reset exits HALT
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("hrst_halt", {31'd0, halt_v[0]}, 32'd0);
    check("hrst_w", {31'd0, w_v[0]}, 32'd1);
    check("hrst_out", {16'd0, out0}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Async reset mid-ADD (GETB) clears before the next edge
    run_instr(0, 16'hD005, 1'b1, cyc);
    run_instr(0, 16'hC020, 1'b1, cyc);
    check("pre_out", {16'd0, out0}, 32'h0005);
    @(negedge clk);
    in_v[0] = 16'hA148; load_v[0] = 1'b1; s_v[0] = 1'b1;
    @(posedge clk); #1;
    load_v[0] = 1'b0; s_v[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("getb_w", {31'd0, w_v[0]}, 32'd0);
    reset = 1'b1;
    #1;
    check("mrst_w", {31'd0, w_v[0]}, 32'd1);
    check("mrst_out", {16'd0, out0}, 32'd0);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_w", {31'd0, w_v[0]}, 32'd1);
    check("post_out", {16'd0, out0}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
